memmu_payload_scheduler: RTL and testbench

Sequences SIU point samples into 64-bit point-cloud payload words and schedules their write-back to point-cloud memory. Sits between the SIU output stream and the MemMU memory write port. Packs each accepted point into the standard payload layout, buffers words in a small FIFO and issues one memory write per word at sequential addresses. Tracks frame boundaries and reports the per-frame point count.

---
 rtl/memmu_payload_scheduler_if.sv | 38 +++
 rtl/memmu_payload_scheduler.sv | 140 ++++++++++++++
 tb/tb_memmu_payload_scheduler.sv | 389 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memmu_payload_scheduler_if.sv
// Handshake and bus bundle between the SIU point stream, the payload scheduler and the memory write port.
// master: scheduler side; slave: SIU/memory environment side.
interface memmu_payload_scheduler_if #(
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] i_MemMU_baseAddr;
   logic [7:0]            i_MemMU_correction;
   logic                  i_SIU_valid;
   logic                  o_MemMU_ready;
   logic                  i_SIU_frameEnd;
   logic [15:0]           i_SIU_distR0;
   logic [15:0]           i_SIU_distR1;
   logic [7:0]            i_SIU_reflR0;
   logic [7:0]            i_SIU_reflR1;
   logic [7:0]            i_SIU_label;
   logic                  o_MemMU_wrValid;
   logic                  i_MEM_wrReady;
   logic [ADDR_WIDTH-1:0] o_MemMU_wrAddr;
   logic [63:0]           o_MemMU_wrData;
   logic                  o_MemMU_frameDone;
   logic [16:0]           o_MemMU_pointCount;

   modport master (
      input  i_MemMU_baseAddr, i_MemMU_correction, i_SIU_valid, i_SIU_frameEnd,
      input  i_SIU_distR0, i_SIU_distR1, i_SIU_reflR0, i_SIU_reflR1, i_SIU_label,
      input  i_MEM_wrReady,
      output o_MemMU_ready, o_MemMU_wrValid, o_MemMU_wrAddr, o_MemMU_wrData,
      output o_MemMU_frameDone, o_MemMU_pointCount
   );

   modport slave (
      output i_MemMU_baseAddr, i_MemMU_correction, i_SIU_valid, i_SIU_frameEnd,
      output i_SIU_distR0, i_SIU_distR1, i_SIU_reflR0, i_SIU_reflR1, i_SIU_label,
      output i_MEM_wrReady,
      input  o_MemMU_ready, o_MemMU_wrValid, o_MemMU_wrAddr, o_MemMU_wrData,
      input  o_MemMU_frameDone, o_MemMU_pointCount
   );
endinterface

// File: rtl/memmu_payload_scheduler.sv
// Packs SIU points into 64-bit payload words, buffers them and writes them to sequential frame-buffer addresses.
// Optional feature: define MEMMU_CORRECTION_EN to carry i_MemMU_correction in payload bits [55:48].
module memmu_payload_scheduler #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int MAX_POINTS = 65536
) (
   input  logic                      i_SYSTEM_clk,
   input  logic                      i_SYSTEM_rst,
   memmu_payload_scheduler_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int IDX_W = $clog2(MAX_POINTS);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MAX_POINTS - 1);
   localparam logic [16:0]      CNT_MAX  = 17'(MAX_POINTS);

   logic [1:0]            state, stateNext;
   logic [63:0]           fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wrPtr, rdPtr;
   logic [PTR_W:0]        occ, occNext;
   logic                  fullQ, emptyQ;
   logic [ADDR_WIDTH-1:0] frameBase;
   logic [IDX_W-1:0]      wrIdx;
   logic [16:0]           pointCnt, pointCntNext, doneCnt;
   logic                  readyInt, push, pop, frameStart;
   logic [7:0]            corrByte;
   logic [63:0]           payload;

   function automatic logic [63:0] packPayload(
      input logic [15:0] distR0, input logic [7:0] reflR0,
      input logic [15:0] distR1, input logic [7:0] reflR1,
      input logic [7:0]  corr,   input logic [7:0] label);
      return {label, corr, reflR1, distR1, reflR0, distR0};
   endfunction

   function automatic logic [16:0] satInc(input logic [16:0] v);
      return (v >= CNT_MAX) ? v : v + 17'd1;
   endfunction

`ifdef MEMMU_CORRECTION_EN
   assign corrByte = bus.i_MemMU_correction;
`else
   logic unusedCorrection;
   assign corrByte         = 8'h00;
   assign unusedCorrection = ^bus.i_MemMU_correction;
`endif

   assign payload = packPayload(bus.i_SIU_distR0, bus.i_SIU_reflR0, bus.i_SIU_distR1,
                                bus.i_SIU_reflR1, corrByte, bus.i_SIU_label);

   // Ready comes from the registered full flag, so a pop never unblocks a push in the same cycle.
   assign readyInt   = !i_SYSTEM_rst && (state == ST_IDLE || state == ST_RUN) && !fullQ;
   assign push       = bus.i_SIU_valid && readyInt;
   assign pop        = !emptyQ && bus.i_MEM_wrReady;
   assign frameStart = push && (state == ST_IDLE);

   always_comb begin
      occNext = occ;
      if (push && !pop)
         occNext = occ + OCC_ONE;
      else if (!push && pop)
         occNext = occ - OCC_ONE;
   end

   always_comb begin
      pointCntNext = pointCnt;
      if (frameStart)
         pointCntNext = 17'd0;
      else if (pop)
         pointCntNext = satInc(pointCnt);
   end

   always_comb begin
      stateNext = state;
      case (state)
         ST_IDLE:  if (push) stateNext = bus.i_SIU_frameEnd ? ST_DRAIN : ST_RUN;
         ST_RUN:   if (push && bus.i_SIU_frameEnd) stateNext = ST_DRAIN;
         // Leave as soon as the final handshake empties the FIFO so frameDone follows it by one cycle.
         ST_DRAIN: if (occNext == '0) stateNext = ST_DONE;
         ST_DONE:  stateNext = ST_IDLE;
         default:  stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_SYSTEM_clk) begin
      if (i_SYSTEM_rst) begin
         state     <= ST_IDLE;
         wrPtr     <= '0;
         rdPtr     <= '0;
         occ       <= '0;
         fullQ     <= 1'b0;
         emptyQ    <= 1'b1;
         frameBase <= '0;
         wrIdx     <= '0;
         pointCnt  <= '0;
         doneCnt   <= '0;
      end else begin
         state    <= stateNext;
         occ      <= occNext;
         fullQ    <= (occNext == OCC_FULL);
         emptyQ   <= (occNext == '0);
         pointCnt <= pointCntNext;
         if (push)
            wrPtr <= wrPtr + PTR_ONE;
         if (pop)
            rdPtr <= rdPtr + PTR_ONE;
         if (frameStart)
            frameBase <= bus.i_MemMU_baseAddr;
         if (frameStart)
            wrIdx <= '0;
         else if (pop)
            wrIdx <= (wrIdx == IDX_LAST) ? '0 : wrIdx + IDX_ONE;
         if (state == ST_DRAIN && stateNext == ST_DONE)
            doneCnt <= pointCntNext;
      end
   end

   always_ff @(posedge i_SYSTEM_clk) begin
      if (push)
         fifoMem[wrPtr] <= payload;
   end

   // The FIFO head is the write request itself; it cannot change until the memory accepts it.
   assign bus.o_MemMU_ready      = readyInt;
   assign bus.o_MemMU_wrValid    = !emptyQ;
   assign bus.o_MemMU_wrData     = emptyQ ? 64'h0 : fifoMem[rdPtr];
   assign bus.o_MemMU_wrAddr     = frameBase + ADDR_WIDTH'({wrIdx, 3'b000});
   assign bus.o_MemMU_frameDone  = (state == ST_DONE);
   assign bus.o_MemMU_pointCount = doneCnt;
endmodule

// File: tb/tb_memmu_payload_scheduler.sv
// Bench for memmu_payload_scheduler: two instances (MAX_POINTS 65536 and 4) share one stimulus stream.
// A frame-level model predicts every write and frame count; build with MEMMU_CORRECTION_EN to cover the correction byte.
module tb_memmu_payload_scheduler;
   localparam int AW   = 32;
   localparam int MAXA = 65536;
   localparam int MAXB = 4;
`ifdef MEMMU_CORRECTION_EN
   localparam bit CORR_ON = 1'b1;
`else
   localparam bit CORR_ON = 1'b0;
`endif

   typedef struct {
      logic [AW-1:0] addr;
      logic [63:0]   data;
   } wr_t;

   typedef struct {
      logic [15:0]   d0;
      logic [7:0]    r0;
      logic [15:0]   d1;
      logic [7:0]    r1;
      logic [7:0]    label;
      logic [7:0]    corr;
      logic [AW-1:0] base;
      logic [AW-1:0] expAddr;
      logic [63:0]   expData;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          valid = 1'b0, frameEnd = 1'b0, wrReady = 1'b0;
   logic [15:0]   d0 = '0, d1 = '0;
   logic [7:0]    r0 = '0, r1 = '0, label = '0, corr = '0;
   logic [AW-1:0] base = '0;

   int nCmp = 0;
   int nErr = 0;

   memmu_payload_scheduler_if #(.ADDR_WIDTH(AW)) busA ();
   memmu_payload_scheduler_if #(.ADDR_WIDTH(AW)) busB ();

   assign busA.i_MemMU_baseAddr = base;     assign busB.i_MemMU_baseAddr = base;
   assign busA.i_MemMU_correction = corr;   assign busB.i_MemMU_correction = corr;
   assign busA.i_SIU_valid = valid;         assign busB.i_SIU_valid = valid;
   assign busA.i_SIU_frameEnd = frameEnd;   assign busB.i_SIU_frameEnd = frameEnd;
   assign busA.i_SIU_distR0 = d0;           assign busB.i_SIU_distR0 = d0;
   assign busA.i_SIU_distR1 = d1;           assign busB.i_SIU_distR1 = d1;
   assign busA.i_SIU_reflR0 = r0;           assign busB.i_SIU_reflR0 = r0;
   assign busA.i_SIU_reflR1 = r1;           assign busB.i_SIU_reflR1 = r1;
   assign busA.i_SIU_label = label;         assign busB.i_SIU_label = label;
   assign busA.i_MEM_wrReady = wrReady;     assign busB.i_MEM_wrReady = wrReady;

   memmu_payload_scheduler #(.FIFO_DEPTH(8), .ADDR_WIDTH(AW), .MAX_POINTS(MAXA)) dutA (
      .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(busA));
   memmu_payload_scheduler #(.FIFO_DEPTH(8), .ADDR_WIDTH(AW), .MAX_POINTS(MAXB)) dutB (
      .i_SYSTEM_clk(clk), .i_SYSTEM_rst(rst), .bus(busB));

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic logic [63:0] pack(input logic [15:0] a0, input logic [7:0] b0,
                                        input logic [15:0] a1, input logic [7:0] b1,
                                        input logic [7:0] lb, input logic [7:0] cr);
      logic [63:0] w;
      w = 64'h0;
      w[15:0]  = a0;
      w[23:16] = b0;
      w[39:24] = a1;
      w[47:40] = b1;
      w[55:48] = CORR_ON ? cr : 8'h00;
      w[63:56] = lb;
      return w;
   endfunction

   // Frame-level reference model and write monitor
   wr_t           expA[$], expB[$];
   int            doneA[$], doneB[$];
   logic [AW-1:0] capA[$], capB[$];
   bit            inFrame = 1'b0;
   logic [AW-1:0] fBase = '0;
   int            nPts = 0;
   bit            stallA = 1'b0, stallB = 1'b0;
   wr_t           holdA, holdB, eA, eB;
   int            dcA, dcB;

   always @(negedge clk) begin
      if (rst) begin
         expA.delete(); expB.delete(); doneA.delete(); doneB.delete();
         inFrame = 1'b0;
         stallA  = 1'b0;
         stallB  = 1'b0;
      end else begin
         if (stallA) begin
            check("stableA_valid", busA.o_MemMU_wrValid, 1);
            check("stableA_addr", busA.o_MemMU_wrAddr, holdA.addr);
            check("stableA_data", busA.o_MemMU_wrData, holdA.data);
         end
         if (stallB) begin
            check("stableB_valid", busB.o_MemMU_wrValid, 1);
            check("stableB_addr", busB.o_MemMU_wrAddr, holdB.addr);
            check("stableB_data", busB.o_MemMU_wrData, holdB.data);
         end
         stallA = busA.o_MemMU_wrValid && !wrReady;
         stallB = busB.o_MemMU_wrValid && !wrReady;
         holdA.addr = busA.o_MemMU_wrAddr; holdA.data = busA.o_MemMU_wrData;
         holdB.addr = busB.o_MemMU_wrAddr; holdB.data = busB.o_MemMU_wrData;

         if (busA.o_MemMU_wrValid && wrReady) begin
            capA.push_back(busA.o_MemMU_wrAddr);
            if (expA.size() == 0) begin
               nCmp++; nErr++;
               $display("FAIL unexpected_write_A: addr 0x%0h, none expected", busA.o_MemMU_wrAddr);
            end else begin
               eA = expA.pop_front();
               check("writeA_addr", busA.o_MemMU_wrAddr, eA.addr);
               check("writeA_data", busA.o_MemMU_wrData, eA.data);
            end
         end
         if (busB.o_MemMU_wrValid && wrReady) begin
            capB.push_back(busB.o_MemMU_wrAddr);
            if (expB.size() == 0) begin
               nCmp++; nErr++;
               $display("FAIL unexpected_write_B: addr 0x%0h, none expected", busB.o_MemMU_wrAddr);
            end else begin
               eB = expB.pop_front();
               check("writeB_addr", busB.o_MemMU_wrAddr, eB.addr);
               check("writeB_data", busB.o_MemMU_wrData, eB.data);
            end
         end

         if (busA.o_MemMU_frameDone) begin
            if (doneA.size() == 0) begin
               nCmp++; nErr++;
               $display("FAIL unexpected_frameDone_A: count %0d, no frame pending", busA.o_MemMU_pointCount);
            end else begin
               dcA = doneA.pop_front();
               check("frameCountA", busA.o_MemMU_pointCount, dcA);
            end
         end
         if (busB.o_MemMU_frameDone) begin
            if (doneB.size() == 0) begin
               nCmp++; nErr++;
               $display("FAIL unexpected_frameDone_B: count %0d, no frame pending", busB.o_MemMU_pointCount);
            end else begin
               dcB = doneB.pop_front();
               check("frameCountB", busB.o_MemMU_pointCount, dcB);
            end
         end

         if (valid && busA.o_MemMU_ready) begin
            if (!inFrame) begin
               inFrame = 1'b1;
               fBase   = base;
               nPts    = 0;
            end
            eA.addr = fBase + AW'(8 * (nPts % MAXA));
            eA.data = pack(d0, r0, d1, r1, label, corr);
            eB.addr = fBase + AW'(8 * (nPts % MAXB));
            eB.data = eA.data;
            expA.push_back(eA);
            expB.push_back(eB);
            nPts++;
            if (frameEnd) begin
               doneA.push_back((nPts < MAXA) ? nPts : MAXA);
               doneB.push_back((nPts < MAXB) ? nPts : MAXB);
               inFrame = 1'b0;
            end
         end
      end
   end

   task automatic setPoint(input logic [15:0] a0, input logic [7:0] b0, input logic [15:0] a1,
                           input logic [7:0] b1, input logic [7:0] lb, input logic [7:0] cr,
                           input logic fe);
      d0 = a0; r0 = b0; d1 = a1; r1 = b1; label = lb; corr = cr; frameEnd = fe;
   endtask

   // Holds valid high until the point is taken; returns just after the accepting edge.
   task automatic sendPoint();
      bit ok;
      ok = 1'b0;
      valid = 1'b1;
      for (int c = 0; c < 300 && !ok; c++) begin
         @(negedge clk);
         if (busA.o_MemMU_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      if (!ok) begin
         nCmp++; nErr++;
         $display("FAIL accept_timeout: point not accepted in 300 cycles, required acceptance");
      end
   endtask

   task automatic waitDone(input string tag, input int cntA, input int cntB);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         if (busA.o_MemMU_frameDone) begin
            seen = 1'b1;
            check({tag, "_countA"}, busA.o_MemMU_pointCount, cntA);
            check({tag, "_countB"}, busB.o_MemMU_pointCount, cntB);
            check({tag, "_doneB"}, busB.o_MemMU_frameDone, 1);
         end
      end
      if (!seen) begin
         nCmp++; nErr++;
         $display("FAIL %s_frameDone_timeout: no frameDone in 400 cycles, required one", tag);
      end
      @(posedge clk); #1;
   endtask

   vec_t       tbl [5];
   int         offs [6];
   int         k, guard, accepted;
   logic [63:0] ed;

   initial begin
      tbl[0] = '{16'h1234, 8'hAB, 16'h5678, 8'hCD, 8'h07, 8'h5A, 32'h0000_1000, 32'h0000_1000, 64'h0700CD5678AB1234};
      tbl[1] = '{16'hFFFF, 8'hFF, 16'hFFFF, 8'hFF, 8'hFF, 8'h00, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 64'hFF00FFFFFFFFFFFF};
      tbl[2] = '{16'h0000, 8'h00, 16'h0000, 8'h00, 8'h00, 8'hFF, 32'h0000_0000, 32'h0000_0000, 64'h0000000000000000};
      tbl[3] = '{16'h0001, 8'h02, 16'h0003, 8'h04, 8'h05, 8'hA5, 32'h0000_2468, 32'h0000_2468, 64'h0500040003020001};
      tbl[4] = '{16'h8000, 8'h80, 16'h0001, 8'h7F, 8'h80, 8'h3C, 32'h8000_0000, 32'h8000_0000, 64'h80007F0001808000};
      offs = '{0, 8, 16, 24, 0, 8};

      // Reset values
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", busA.o_MemMU_ready, 0);
      check("rst_wrValid", busA.o_MemMU_wrValid, 0);
      check("rst_wrAddr", busA.o_MemMU_wrAddr, 0);
      check("rst_wrData", busA.o_MemMU_wrData, 0);
      check("rst_frameDone", busA.o_MemMU_frameDone, 0);
      check("rst_pointCount", busA.o_MemMU_pointCount, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", busA.o_MemMU_ready, 1);
      @(posedge clk); #1;

      // Single-point frames from the vector table: latency, packing, frameDone timing
      wrReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         ed = tbl[i].expData | (CORR_ON ? {8'h00, tbl[i].corr, 48'h0} : 64'h0);
         base = tbl[i].base;
         setPoint(tbl[i].d0, tbl[i].r0, tbl[i].d1, tbl[i].r1, tbl[i].label, tbl[i].corr, 1'b1);
         sendPoint();
         valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d_wrValid", i), busA.o_MemMU_wrValid, 1);
         check($sformatf("vec%0d_addr", i), busA.o_MemMU_wrAddr, tbl[i].expAddr);
         check($sformatf("vec%0d_data", i), busA.o_MemMU_wrData, ed);
         check($sformatf("vec%0d_addrB", i), busB.o_MemMU_wrAddr, tbl[i].expAddr);
         @(negedge clk);
         check($sformatf("vec%0d_frameDone", i), busA.o_MemMU_frameDone, 1);
         check($sformatf("vec%0d_count", i), busA.o_MemMU_pointCount, 1);
         @(negedge clk);
         check($sformatf("vec%0d_doneDrop", i), busA.o_MemMU_frameDone, 0);
         check($sformatf("vec%0d_countHeld", i), busA.o_MemMU_pointCount, 1);
         @(posedge clk); #1;
      end

      // 20 points against a stalled memory: FIFO fills at 8, then drains in order
      capA.delete(); capB.delete();
      base = 32'h0000_1000;
      wrReady = 1'b0;
      k = 0;
      for (int c = 0; c < 12; c++) begin
         setPoint(16'h0100 + 16'(k), 8'(k), 16'h0200 + 16'(k), 8'hC0, 8'(k + 1), 8'h11, 1'b0);
         valid = 1'b1;
         @(negedge clk);
         if (busA.o_MemMU_ready) k++;
         @(posedge clk); #1;
      end
      check("bp_accepted_before_full", k, 8);
      check("bp_ready_low", busA.o_MemMU_ready, 0);
      wrReady = 1'b1;
      guard = 0;
      while (k < 20 && guard < 300) begin
         setPoint(16'h0100 + 16'(k), 8'(k), 16'h0200 + 16'(k), 8'hC0, 8'(k + 1), 8'h11, k == 19);
         valid = 1'b1;
         @(negedge clk);
         if (busA.o_MemMU_ready) k++;
         @(posedge clk); #1;
         guard++;
      end
      valid = 1'b0;
      check("bp_all_accepted", k, 20);
      waitDone("bp", 20, 4);
      check("bp_write_total", capA.size(), 20);
      for (int i = 0; i < 20 && i < capA.size(); i++)
         check($sformatf("bp_addr%0d", i), capA[i], 32'h0000_1000 + 32'(8 * i));

      // Six-point frame: the MAX_POINTS=4 instance wraps its index and saturates its count
      capA.delete(); capB.delete();
      base = 32'h0000_2000;
      for (int i = 0; i < 6; i++) begin
         setPoint(16'(i), 8'h10, 16'(i * 3), 8'h20, 8'h30, 8'h40, i == 5);
         sendPoint();
      end
      valid = 1'b0;
      waitDone("max", 6, 4);
      check("max_writesB", capB.size(), 6);
      for (int i = 0; i < 6 && i < capB.size(); i++)
         check($sformatf("max_addrB%0d", i), capB[i], 32'h0000_2000 + 32'(offs[i]));

      // Reset after 3 of 5 points: pending words discarded, no frameDone, next frame restarts
      base = 32'h0000_3000;
      wrReady = 1'b0;
      for (int i = 0; i < 3; i++) begin
         setPoint(16'hAAA0 + 16'(i), 8'h01, 16'hBBB0, 8'h02, 8'h03, 8'h04, 1'b0);
         sendPoint();
      end
      valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("midrst_ready_low", busA.o_MemMU_ready, 0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_wrValid", busA.o_MemMU_wrValid, 0);
      check("midrst_wrAddr", busA.o_MemMU_wrAddr, 0);
      check("midrst_wrData", busA.o_MemMU_wrData, 0);
      check("midrst_pointCount", busA.o_MemMU_pointCount, 0);
      check("midrst_ready", busA.o_MemMU_ready, 1);
      wrReady = 1'b1;
      k = 0;
      repeat (10) begin
         @(negedge clk);
         if (busA.o_MemMU_frameDone || busA.o_MemMU_wrValid) k++;
      end
      check("midrst_quiet_cycles", k, 0);
      @(posedge clk); #1;
      capA.delete(); capB.delete();
      base = 32'h0000_4000;
      for (int i = 0; i < 2; i++) begin
         setPoint(16'h0F00 + 16'(i), 8'h55, 16'h0E00, 8'h66, 8'h77, 8'h5A, i == 1);
         sendPoint();
      end
      valid = 1'b0;
      waitDone("postrst", 2, 2);
      check("postrst_writes", capA.size(), 2);
      if (capA.size() == 2) begin
         check("postrst_addr0", capA[0], 32'h0000_4000);
         check("postrst_addr1", capA[1], 32'h0000_4008);
      end

      // Randomized traffic with memory stalls and random frame ends
      accepted = 0;
      guard = 0;
      while (accepted < 100 && guard < 20000) begin
         wrReady = ($urandom_range(0, 99) < 60);
         base = $urandom;
         setPoint(16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), (accepted == 99) || ($urandom_range(0, 24) == 0));
         valid = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         if (valid && busA.o_MemMU_ready) accepted++;
         @(posedge clk); #1;
         guard++;
      end
      valid = 1'b0;
      wrReady = 1'b1;
      check("rand_accepted", accepted, 100);
      for (int c = 0; c < 500 && (expA.size() != 0 || doneA.size() != 0 || doneB.size() != 0); c++)
         @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rand_pendingA", expA.size(), 0);
      check("rand_pendingB", expB.size(), 0);
      check("rand_doneA", doneA.size(), 0);
      check("rand_doneB", doneB.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in 90000 cycles, required completion");
      $fatal(1, "watchdog");
   end
endmodule
